// File: rtl/vote_pkg.sv
// Shared definitions for the majority-vote front end and its consumers.
//   N_VOTE     : number of voter channels feeding majority_vote
//   ch_state_t : per-channel debounce state
package vote_pkg;

  localparam int N_VOTE = 3;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } ch_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One voter channel: 2-FF synchroniser, debounce FSM and run-length counter.
// A new input level is accepted only after it has been seen on the
// synchronised input for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous, active-high reset
//   raw_i    in   asynchronous raw switch/button level
//   x_o      out  debounced level
//   rise_o   out  1-cycle strobe on an accepted 0->1 change
//   fall_o   out  1-cycle strobe on an accepted 1->0 change
//   stable_o out  1 while the FSM is in ST_STABLE
module debounce_channel
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic x_o,
  output logic rise_o,
  output logic fall_o,
  output logic stable_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             mismatch;

  // NOTE: every register here uses non-blocking assignment so all flops
  // update together on the edge; blocking would collapse s1/s2 into one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // Two-stage synchroniser: only s2_q is allowed to reach the FSM.
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign mismatch = s2_q ^ x_q;

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (mismatch) begin
          state_d = ST_CHANGING;
          cnt_d   = CNT_W'(1);
        end
      end

      ST_CHANGING: begin
        if (!mismatch) begin
          // Input returned before the run completed: treat as a glitch.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // This is the DEBOUNCE_CYCLES-th consecutive mismatch: commit.
          state_d = ST_STABLE;
          cnt_d   = '0;
          x_d     = s2_q;
          rise_d  = s2_q;
          fall_d  = ~s2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign x_o      = x_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign stable_o = (state_q == ST_STABLE);

endmodule

// File: rtl/vote_input_debouncer.sv
// Front end for majority_vote: replicates one debounce_channel per voter
// input and reports when every channel is settled.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   raw_i      in   N_CH asynchronous raw inputs (bit0->x0, bit1->x1, ...)
//   x_o        out  N_CH debounced levels for majority_vote
//   rise_o     out  N_CH 1-cycle strobes on accepted 0->1 changes
//   fall_o     out  N_CH 1-cycle strobes on accepted 1->0 changes
//   settled_o  out  1 when every channel is in ST_STABLE
module vote_input_debouncer
  import vote_pkg::*;
#(
  parameter int N_CH            = N_VOTE,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_i,
  output logic [N_CH-1:0] x_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic            settled_o
);

  logic [N_CH-1:0] stable_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw_i[i]),
      .x_o     (x_o[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i]),
      .stable_o(stable_w[i])
    );
  end

  assign settled_o = &stable_w;

endmodule

// File: tb/tb_vote_input_debouncer.sv
module tb_vote_input_debouncer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] raw_i;
  logic [2:0] x_o, rise_o, fall_o;
  logic       settled_o;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  vote_input_debouncer #(
    .N_CH(3),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (raw_i),
    .x_o      (x_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .settled_o(settled_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic maj(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Reference model: a change is accepted once the input, seen two clocks
  // late, has disagreed with the output for D consecutive cycles.
  logic [2:0] hist[2];
  logic [2:0] m_x, m_rise, m_fall;
  int         run[3];

  always @(posedge clk) begin
    logic [2:0] seen;
    if (rst) begin
      hist[0] = '0;
      hist[1] = '0;
      m_x = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < 3; i++) run[i] = 0;
    end else begin
      seen = hist[1];
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < 3; i++) begin
        if (seen[i] != m_x[i]) begin
          run[i]++;
          if (run[i] == D) begin
            m_x[i] = seen[i];
            if (seen[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      hist[1] = hist[0];
      hist[0] = raw_i;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_x", 32'(x_o), 32'(m_x));
      check("model_rise", 32'(rise_o), 32'(m_rise));
      check("model_fall", 32'(fall_o), 32'(m_fall));
      check("model_settled", 32'(settled_o),
            32'(run[0] == 0 && run[1] == 0 && run[2] == 0));
    end
  end

  typedef struct {
    logic [2:0] raw;
    int         hold;
    logic [2:0] exp_x;
    logic       exp_settled;
    logic       exp_y;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b000, 10, 3'b000, 1'b1, 1'b0};
    vecs[1] = '{3'b001, 10, 3'b001, 1'b1, 1'b0};
    vecs[2] = '{3'b010, 10, 3'b010, 1'b1, 1'b0};
    vecs[3] = '{3'b011, 10, 3'b011, 1'b1, 1'b1};
    vecs[4] = '{3'b100, 10, 3'b100, 1'b1, 1'b0};
    vecs[5] = '{3'b101, 10, 3'b101, 1'b1, 1'b1};
    vecs[6] = '{3'b110, 10, 3'b110, 1'b1, 1'b1};
    vecs[7] = '{3'b111, 10, 3'b111, 1'b1, 1'b1};

    // 1: reset with all inputs high, then re-debounce after release.
    rst   = 1'b1;
    raw_i = 3'b111;
    step(2);
    check("rst_x", 32'(x_o), 32'h0);
    check("rst_rise", 32'(rise_o), 32'h0);
    check("rst_fall", 32'(fall_o), 32'h0);
    check("rst_settled", 32'(settled_o), 32'h1);
    rst    = 1'b0;
    chk_en = 1'b1;
    step(5);
    check("t1_x_before", 32'(x_o), 32'h0);
    step(1);
    check("t1_x", 32'(x_o), 32'h7);
    check("t1_rise", 32'(rise_o), 32'h7);
    check("t1_y", 32'(maj(x_o)), 32'h1);
    step(1);
    check("t1_rise_drop", 32'(rise_o), 32'h0);
    check("t1_x_hold", 32'(x_o), 32'h7);

    // 2: single channel rise, settled drops from e0+2.
    raw_i = 3'b000;
    step(10);
    check("t2_pre_x", 32'(x_o), 32'h0);
    raw_i = 3'b001;
    step(2);
    check("t2_settled_e1", 32'(settled_o), 32'h1);
    step(1);
    check("t2_settled_e2", 32'(settled_o), 32'h0);
    step(2);
    check("t2_x_e4", 32'(x_o), 32'h0);
    step(1);
    check("t2_x_e5", 32'(x_o), 32'h1);
    check("t2_rise_e5", 32'(rise_o), 32'h1);
    check("t2_settled_e5", 32'(settled_o), 32'h1);
    check("t2_y", 32'(maj(x_o)), 32'h0);

    // 3a: 3-cycle glitch on channel 1 is rejected.
    raw_i = 3'b011;
    step(3);
    raw_i = 3'b001;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("t3_glitch_x", 32'(x_o), 32'h1);
      check("t3_glitch_strobe", 32'({rise_o, fall_o}), 32'h0);
    end
    check("t3_glitch_settled", 32'(settled_o), 32'h1);

    // 3b: 4-cycle pulse is accepted, then its fall is accepted too.
    raw_i = 3'b011;
    step(4);
    raw_i = 3'b001;
    step(2);
    check("t3_pulse_x", 32'(x_o), 32'h3);
    check("t3_pulse_rise", 32'(rise_o), 32'h2);
    step(3);
    check("t3_pulse_nofall", 32'(fall_o), 32'h0);
    step(1);
    check("t3_pulse_fall", 32'(fall_o), 32'h2);
    check("t3_pulse_x_back", 32'(x_o), 32'h1);

    // 4: walk every input combination.
    for (int i = 0; i < 8; i++) begin
      raw_i = vecs[i].raw;
      step(vecs[i].hold);
      check($sformatf("t4_x_%0d", i), 32'(x_o), 32'(vecs[i].exp_x));
      check($sformatf("t4_settled_%0d", i), 32'(settled_o), 32'(vecs[i].exp_settled));
      check($sformatf("t4_y_%0d", i), 32'(maj(x_o)), 32'(vecs[i].exp_y));
    end

    // 5: two channels commit on the same edge.
    raw_i = 3'b000;
    step(10);
    raw_i = 3'b011;
    step(5);
    check("t5_rise_e4", 32'(rise_o), 32'h0);
    check("t5_y_e4", 32'(maj(x_o)), 32'h0);
    step(1);
    check("t5_rise_e5", 32'(rise_o), 32'h3);
    check("t5_y_e5", 32'(maj(x_o)), 32'h1);

    // 6: reset in the middle of a change on channel 2.
    raw_i = 3'b111;
    step(4);
    check("t6_changing", 32'(settled_o), 32'h0);
    rst = 1'b1;
    step(1);
    check("t6_rst_x", 32'(x_o), 32'h0);
    check("t6_rst_strobe", 32'({rise_o, fall_o}), 32'h0);
    check("t6_rst_settled", 32'(settled_o), 32'h1);
    rst = 1'b0;
    step(5);
    check("t6_x_e4", 32'(x_o), 32'h0);
    step(1);
    check("t6_x_e5", 32'(x_o), 32'h7);
    check("t6_rise_e5", 32'(rise_o), 32'h7);

    // Random phase: random levels held for random spans, checked by the model.
    repeat (300) begin
      raw_i = 3'($urandom);
      step(int'($urandom_range(1, 7)));
    end
    step(12);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
